// File: rtl/uart_time_pkg.sv
// Shared definitions for the UART time-adjust frame parser: header defaults,
// FSM encoding, error codes, payload field indices and BCD field limits.
package uart_time_pkg;

    localparam logic [7:0] HDR0_DEF = 8'h55;
    localparam logic [7:0] HDR1_DEF = 8'hAA;

    localparam int unsigned NUM_FIELDS = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    localparam logic [1:0] ERR_OVERRUN  = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_RANGE    = 2'd3;

    // Payload byte order on the wire, also the byte lane in the time word
    localparam int unsigned SEC   = 0;
    localparam int unsigned MIN   = 1;
    localparam int unsigned HOUR  = 2;
    localparam int unsigned WEEK  = 3;
    localparam int unsigned DAY   = 4;
    localparam int unsigned MONTH = 5;
    localparam int unsigned YEAR  = 6;

    // Inclusive BCD limits per field, indexed by the constants above
    localparam logic [7:0] FIELD_MIN [NUM_FIELDS] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
    localparam logic [7:0] FIELD_MAX [NUM_FIELDS] = '{8'h59, 8'h59, 8'h23, 8'h06, 8'h31, 8'h12, 8'h99};

    // Both nibbles must be decimal digits; for valid BCD the binary order
    // matches the decimal order, so limits compare directly.
    function automatic logic bcd_in_range(input logic [7:0] val,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        logic digits_ok;
        digits_ok = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9);
        return digits_ok && (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational range check of the seven BCD time fields.
module bcd_time_check
    import uart_time_pkg::*;
(
    input  logic [55:0] payload_i,
    output logic        range_ok_o
);

    logic [NUM_FIELDS-1:0] field_ok_s;

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
        assign field_ok_s[g] = bcd_in_range(payload_i[g*8 +: 8], FIELD_MIN[g], FIELD_MAX[g]);
    end

    assign range_ok_o = &field_ok_s;

endmodule

// File: rtl/uart_time_frame_parser.sv
// Assembles HDR0 HDR1 sec min hour week day month year CSUM frames from the
// UART byte stream and offers each good frame as one 56-bit BCD time word.
module uart_time_frame_parser
    import uart_time_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter logic [7:0]  HDR0        = HDR0_DEF,
    parameter logic [7:0]  HDR1        = HDR1_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    output logic [55:0] time_data,
    output logic        time_vld,
    input  logic        time_rdy,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_e        state_q;
    logic [55:0]   payload_q;
    logic [2:0]    cnt_q;
    logic [7:0]    sum_q;
    logic [TW-1:0] tmo_q;
    logic [55:0]   time_data_q;
    logic          time_vld_q;
    logic          frame_err_q;
    logic [1:0]    err_code_q;
    logic          range_ok_s;
    logic          tmo_hit_s;
    logic [5:0]    byte_lsb_s;

    bcd_time_check u_check (
        .payload_i  (payload_q),
        .range_ok_o (range_ok_s)
    );

    assign tmo_hit_s  = (tmo_q == TMO_LAST);
    assign byte_lsb_s = {cnt_q, 3'b000};

    // Frame FSM: byte path, inter-byte timeout, checksum/range verdict and hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            payload_q   <= 56'd0;
            cnt_q       <= 3'd0;
            sum_q       <= 8'd0;
            tmo_q       <= '0;
            time_data_q <= 56'd0;
            time_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tmo_q <= '0;
                    if (rx_done && (rx_byte == HDR0)) begin
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR, ST_PAYLOAD, ST_CSUM: begin
                    if (rx_done) begin
                        // A byte on the terminal count still wins over the timeout
                        tmo_q <= '0;
                        if (state_q == ST_HDR) begin
                            if (rx_byte == HDR1) begin
                                state_q <= ST_PAYLOAD;
                                cnt_q   <= 3'd0;
                                sum_q   <= 8'd0;
                            end else if (rx_byte != HDR0) begin
                                state_q <= ST_IDLE;
                            end
                        end else if (state_q == ST_PAYLOAD) begin
                            payload_q[byte_lsb_s +: 8] <= rx_byte;
                            sum_q <= sum_q + rx_byte;
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd6) begin
                                state_q <= ST_CSUM;
                            end
                        end else if (rx_byte != sum_q) begin
                            state_q     <= ST_IDLE;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHECKSUM;
                        end else if (!range_ok_s) begin
                            state_q     <= ST_IDLE;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_RANGE;
                        end else begin
                            state_q     <= ST_HOLD;
                            time_data_q <= payload_q;
                            time_vld_q  <= 1'b1;
                        end
                    end else if (tmo_hit_s) begin
                        state_q     <= ST_IDLE;
                        tmo_q       <= '0;
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    tmo_q <= '0;
                    if (time_rdy) begin
                        state_q    <= ST_IDLE;
                        time_vld_q <= 1'b0;
                    end
                    // No buffer for a second frame: the byte is lost and flagged
                    if (rx_done) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_OVERRUN;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tmo_q      <= '0;
                    time_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign time_data = time_data_q;
    assign time_vld  = time_vld_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_time_frame_parser.md
Name: uart_time_frame_parser

Overview:
Consumes the byte stream from the UART byte receiver (rx_byte/rx_done) and assembles time-adjust frames for the SD30xx RTC path. It validates header, checksum, BCD ranges and inter-byte timing. Each good frame is presented as one 56-bit time word over a valid/ready handshake to the downstream RTC write controller. Bad frames are reported as single-cycle error pulses with a code.

Parameters:
TIMEOUT_CYC, 500000, max clk cycles between consecutive rx_done pulses inside a frame (10 ms at 50 MHz)
HDR0, 8'h55, first header byte
HDR1, 8'hAA, second header byte

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous reset, active-low
rx_byte  input  8  received byte, valid in the cycle rx_done=1
rx_done  input  1  single-cycle byte strobe from the UART receiver
time_data  output  56  {year,month,day,week,hour,min,sec}; sec=[7:0], year=[55:48]; all BCD
time_vld  output  1  frame accepted; held until handshake
time_rdy  input  1  downstream accepts time_data while time_vld=1
frame_err  output  1  one-cycle error pulse
err_code  output  2  0=overrun, 1=timeout, 2=checksum, 3=range; valid with frame_err, holds last value otherwise
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; time_data=0, time_vld=0, frame_err=0, err_code=0, busy=0; payload regs, byte counter, checksum accumulator and timeout counter all 0.
- Frame format: HDR0, HDR1, 7 payload bytes (sec,min,hour,week,day,month,year), CSUM. CSUM = 8-bit sum mod 256 of the 7 payload bytes; headers are excluded.
- States: IDLE, HDR, PAYLOAD, CSUM, HOLD. Only cycles with rx_done=1 advance the byte path.
- IDLE: byte==HDR0 -> HDR. All other bytes are ignored silently.
- HDR: byte==HDR1 -> PAYLOAD, clear cnt and sum. byte==HDR0 -> stay in HDR (resync, so 55 55 AA is accepted). Any other byte -> IDLE, no error.
- PAYLOAD: store byte at index cnt, sum += byte, cnt++. After cnt==6 is stored -> CSUM.
- CSUM, on byte arrival:
  - byte != sum -> IDLE, frame_err with code 2.
  - else any field out of range -> IDLE, frame_err with code 3. Checksum error has priority over range error.
  - else load time_data, set time_vld=1 -> HOLD.
  - Latency: time_vld is high in the cycle after the CSUM rx_done.
- Range rules:
  - Every nibble must be <=9.
  - sec and min 00-59; hour 00-23 (bit7=0, 24h only); week 00-06; day 01-31; month 01-12; year 00-99.
  - No month/day cross-check.
- HOLD: time_vld stays high and time_data stays stable until time_rdy=1 is sampled. Next cycle time_vld=0 and state returns to IDLE.
  - rx_done during HOLD: the byte is dropped and frame_err fires with code 0. The state stays HOLD.
  - Handshake and overrun in the same cycle: the handshake completes and the overrun is still reported.
- Timeout: the counter runs only in HDR, PAYLOAD and CSUM, and clears on every rx_done.
  - Reaching TIMEOUT_CYC-1 -> IDLE, frame_err with code 1, payload discarded.
  - rx_done in the same cycle as the terminal count: the byte wins, the counter clears and there is no timeout.
- frame_err is a registered pulse, exactly 1 cycle wide; err_code is updated in the same cycle.
- Asynchronous reset mid-frame or in HOLD aborts immediately: no pulse, time_vld=0.

Decomposition:
- Package uart_time_pkg: HDR0/HDR1 defaults, state encoding, err_code constants, field index constants (SEC=0..YEAR=6), per-field max-value constants.
- Sub-module bcd_time_check: combinational; 7x8-bit payload in, range_ok out. It instantiates the per-field nibble and range compares.

Test Plan:
- Good frame 55 AA 30 45 12 03 15 06 24 C9 -> time_vld=1 one cycle after the last rx_done; time_data=56'h24_06_15_03_12_45_30. time_rdy=1 three cycles later -> time_vld=0 next cycle, busy=0.
- Same frame with CSUM=C8 -> frame_err pulse, err_code=2, time_vld stays 0, state IDLE.
- Frame with sec=0x60 and CSUM corrected to F9 -> frame_err, err_code=3. Repeat with min=0x4A (CSUM adjusted) -> err_code=3.
- 55 AA 30 45, then no rx_done for TIMEOUT_CYC cycles (bench overrides to 100) -> frame_err, err_code=1. A following good frame is accepted normally.
- Stream 12 55 55 AA plus the good payload/CSUM -> accepted, time_data as in scenario 1. Stream 55 13 AA ... -> no output, no error.
- time_rdy held 0 after a good frame, then a byte 0x55 arrives -> frame_err, err_code=0, time_vld and time_data unchanged. rstn asserted during HOLD -> all outputs 0 immediately.
